// File: rtl/output_wormhole_arbiter.sv
// output_wormhole_arbiter: round-robin wormhole arbiter that locks one input from HEAD to TAIL and drives a registered output flit.
// Defining OUT_ARB_PKT_CNT_EN enables the forwarded-packet counter on pkt_cnt_o; otherwise pkt_cnt_o is tied to 0.
module output_wormhole_arbiter #(
   parameter int NUM_INPUTS    = 4,
   parameter int FLIT_WIDTH    = 34,
   parameter int PKT_CNT_WIDTH = 16
) (
   input  logic                             clk,
   input  logic                             arst,
   input  logic [NUM_INPUTS-1:0]            req_i,
   input  logic [NUM_INPUTS-1:0]            fin_valid_i,
   input  logic [NUM_INPUTS*FLIT_WIDTH-1:0] fin_data_i,
   output logic [NUM_INPUTS-1:0]            fin_ready_o,
   output logic                             fout_valid_o,
   output logic [FLIT_WIDTH-1:0]            fout_data_o,
   input  logic                             fout_ready_i,
   output logic [PKT_CNT_WIDTH-1:0]         pkt_cnt_o
);
   localparam int PW = $clog2(NUM_INPUTS);
   localparam logic [PW:0] NI = NUM_INPUTS[PW:0];
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t state, state_n;
   logic [PW-1:0] rr_ptr, rr_ptr_n, grant, grant_n, win, sel, sel_inc;
   logic [PW:0] idx;
   logic [NUM_INPUTS-1:0] elig;
   logic pipe_ready, found, act, xfer;
   logic [FLIT_WIDTH-1:0] flit;
   logic [1:0] ftype;
   always_comb begin
      pipe_ready = !fout_valid_o || fout_ready_i;
      for (int k = 0; k < NUM_INPUTS; k++)
         elig[k] = req_i[k] && fin_valid_i[k] &&
                   (fin_data_i[k*FLIT_WIDTH+FLIT_WIDTH-1] == fin_data_i[k*FLIT_WIDTH+FLIT_WIDTH-2]);
      // scan eligible heads starting at rr_ptr, wrapping without a power-of-2 assumption
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         idx = {1'b0, rr_ptr} + (PW+1)'(i);
         if (idx >= NI) idx = idx - NI;
         if (!found && elig[idx[PW-1:0]]) begin
            found = 1'b1;
            win   = idx[PW-1:0];
         end
      end
      sel         = (state == LOCKED) ? grant : win;
      act         = (state == LOCKED) || found;
      sel_inc     = (sel == PW'(NUM_INPUTS-1)) ? '0 : sel + 1'b1;
      flit        = fin_data_i[sel*FLIT_WIDTH +: FLIT_WIDTH];
      ftype       = flit[FLIT_WIDTH-1 -: 2];
      fin_ready_o = (act && !arst) ? NUM_INPUTS'(pipe_ready) << sel : '0;
      xfer        = act && pipe_ready && fin_valid_i[sel] && !arst;
      state_n     = state;
      rr_ptr_n    = rr_ptr;
      grant_n     = grant;
      if (xfer && state == IDLE && ftype == 2'b00) begin
         state_n = LOCKED;
         grant_n = sel;
      end else if (xfer && (state == IDLE || ftype == 2'b10)) begin
         state_n  = IDLE;
         rr_ptr_n = sel_inc;
      end
   end
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         grant        <= '0;
         fout_valid_o <= 1'b0;
         fout_data_o  <= '0;
      end else begin
         state  <= state_n;
         rr_ptr <= rr_ptr_n;
         grant  <= grant_n;
         if (xfer) begin
            fout_valid_o <= 1'b1;
            fout_data_o  <= flit;
         end else if (fout_ready_i) begin
            fout_valid_o <= 1'b0;
         end
      end
   end
`ifdef OUT_ARB_PKT_CNT_EN
   always_ff @(posedge clk or posedge arst) begin
      if (arst) pkt_cnt_o <= '0;
      else if (xfer && ftype[1]) pkt_cnt_o <= pkt_cnt_o + 1'b1;
   end
`else
   assign pkt_cnt_o = '0;
`endif
endmodule

// File: tb/tb_output_wormhole_arbiter.sv
// tb_output_wormhole_arbiter: randomized packet traffic against a queue-free behavioural arbiter model.
module tb_output_wormhole_arbiter;
   localparam int N = 4, FW = 34, CW = 16;
   logic clk = 1'b0, arst;
   logic [N-1:0] req_i, fin_valid_i, fin_ready_o;
   logic [N*FW-1:0] fin_data_i;
   logic fout_valid_o, fout_ready_i;
   logic [FW-1:0] fout_data_o;
   logic [CW-1:0] pkt_cnt_o;

   output_wormhole_arbiter #(.NUM_INPUTS(N), .FLIT_WIDTH(FW), .PKT_CNT_WIDTH(CW)) dut (
      .clk(clk), .arst(arst), .req_i(req_i), .fin_valid_i(fin_valid_i), .fin_data_i(fin_data_i),
      .fin_ready_o(fin_ready_o), .fout_valid_o(fout_valid_o), .fout_data_o(fout_data_o),
      .fout_ready_i(fout_ready_i), .pkt_cnt_o(pkt_cnt_o));

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   int len[N], pos[N];
   bit junk[N];
   logic [31:0] pay[N];
   bit m_locked, m_vld;
   int m_owner, m_ptr, e_sel;
   logic [FW-1:0] m_data;
   logic [CW-1:0] m_cnt;
   bit e_xfer;
   logic [N-1:0] e_ready;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic new_pkt(input int k);
      len[k]  = 1 + int'($urandom % 4);
      pos[k]  = 0;
      junk[k] = ($urandom % 12 == 0);
      pay[k]  = $urandom;
   endtask

   function automatic logic [1:0] gen_type(input int k);
      if (junk[k] && pos[k] == 0) return 2'b01;
      if (len[k] == 1) return 2'b11;
      if (pos[k] == 0) return 2'b00;
      if (pos[k] == len[k] - 1) return 2'b10;
      return 2'b01;
   endfunction

   task automatic model_reset();
      m_locked = 0; m_owner = 0; m_ptr = 0; m_vld = 0; m_data = '0; m_cnt = '0;
      for (int k = 0; k < N; k++) new_pkt(k);
   endtask

   // ph 0 random traffic, 1 all inputs HEAD_TAIL, 3 lone BODY on input 3, 4 HEADs on inputs 1 and 3
   task automatic drive(input int ph);
      fout_ready_i = (ph == 0) ? ($urandom % 4 != 0) : 1'b1;
      for (int k = 0; k < N; k++) begin
         logic [1:0] t;
         if (junk[k] && $urandom % 4 == 0) junk[k] = 0;
         t = gen_type(k);
         case (ph)
            1: begin fin_valid_i[k] = 1'b1; req_i[k] = 1'b1; t = 2'b11; end
            3: begin fin_valid_i[k] = (k == 3); req_i[k] = (k == 3); t = 2'b01; end
            4: begin fin_valid_i[k] = (k == 1 || k == 3); req_i[k] = fin_valid_i[k]; t = 2'b00; end
            default: begin
               fin_valid_i[k] = ($urandom % 4 != 0);
               req_i[k] = fin_valid_i[k] ? ($urandom % 8 != 0) : 1'($urandom % 2);
            end
         endcase
         fin_data_i[k*FW +: FW] = {t, pay[k]};
      end
   endtask

   task automatic model_eval();
      bit pr, act;
      logic [1:0] t;
      pr = !m_vld || fout_ready_i;
      act = m_locked;
      e_sel = m_owner;
      if (!m_locked)
         for (int i = 0; i < N; i++) begin
            int j;
            j = (m_ptr + i) % N;
            t = fin_data_i[j*FW+FW-2 +: 2];
            if (!act && req_i[j] && fin_valid_i[j] && (t == 2'b00 || t == 2'b11)) begin
               act = 1; e_sel = j;
            end
         end
      e_ready = '0;
      if (act && pr) e_ready[e_sel] = 1'b1;
      e_xfer = act && pr && fin_valid_i[e_sel];
   endtask

   task automatic model_commit(input int ph);
      logic [FW-1:0] flit;
      logic [1:0] t;
      if (e_xfer) begin
         flit = fin_data_i[e_sel*FW +: FW];
         t = flit[FW-1 -: 2];
         m_vld = 1; m_data = flit;
         if (!m_locked) begin
            if (t == 2'b00) begin m_locked = 1; m_owner = e_sel; end
            else m_ptr = (e_sel + 1) % N;
         end else if (t == 2'b10) begin
            m_locked = 0; m_ptr = (m_owner + 1) % N;
         end
`ifdef OUT_ARB_PKT_CNT_EN
         if (t == 2'b10 || t == 2'b11) m_cnt = m_cnt + 1'b1;
`endif
         pay[e_sel] = $urandom;
         if (ph == 0) begin
            pos[e_sel]++;
            if (pos[e_sel] >= len[e_sel]) new_pkt(e_sel);
         end
      end else if (fout_ready_i) m_vld = 0;
   endtask

   initial begin
      int ph, rst_cyc;
      bit rst_done;
      rst_done = 0; rst_cyc = -10;
      arst = 1'b1; fout_ready_i = 1'b0; req_i = '0; fin_valid_i = '0; fin_data_i = '0;
      model_reset();
      @(posedge clk); #1;
      check("rst_valid", 64'(fout_valid_o), 64'(0));
      check("rst_data", 64'(fout_data_o), 64'(0));
      check("rst_ready", 64'(fin_ready_o), 64'(0));
      check("rst_cnt", 64'(pkt_cnt_o), 64'(0));
      @(posedge clk); #1 arst = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         ph = (cyc < 200) ? 1 : (cyc < 220) ? 3 : (cyc == rst_cyc + 1) ? 4 : 0;
         drive(ph);
         #1;
         model_eval();
         check("fin_ready", 64'(fin_ready_o), 64'(e_ready));
         @(posedge clk);
         model_commit(ph);
         #1;
         check("fout_valid", 64'(fout_valid_o), 64'(m_vld));
         check("fout_data", 64'(fout_data_o), 64'(m_data));
         check("pkt_cnt", 64'(pkt_cnt_o), 64'(m_cnt));
         if (cyc >= 1500 && !rst_done && m_locked) begin
            arst = 1'b1;
            #1;
            check("midrst_valid", 64'(fout_valid_o), 64'(0));
            check("midrst_data", 64'(fout_data_o), 64'(0));
            check("midrst_ready", 64'(fin_ready_o), 64'(0));
            model_reset();
            @(posedge clk); #1 arst = 1'b0;
            rst_done = 1; rst_cyc = cyc;
         end
      end
      check("midrst_seen", 64'(rst_done), 64'(1));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/output_wormhole_arbiter.md
Name: output_wormhole_arbiter

Overview:
Per-direction output stage sitting directly downstream of the router's input modules. Collects flit requests from every input module that targets this output port and grants one packet at a time in round-robin order. Holds the grant (wormhole lock) from head flit through tail flit. Drives the granted flit through a single registered stage toward the next router or local NI.

Parameters:
NUM_INPUTS, 4, number of competing input modules (2..8)
FLIT_WIDTH, 34, flit width in bits; type field is bits [FLIT_WIDTH-1:FLIT_WIDTH-2]
PKT_CNT_WIDTH, 16, width of the forwarded-packet counter

Ports:
clk  input  1  router clock
arst  input  1  asynchronous active-high reset
req_i  input  NUM_INPUTS  per-input request for this output port (from input router decode)
fin_valid_i  input  NUM_INPUTS  per-input flit valid
fin_data_i  input  NUM_INPUTS*FLIT_WIDTH  per-input flit; input k occupies bits [k*FLIT_WIDTH +: FLIT_WIDTH]
fin_ready_o  output  NUM_INPUTS  per-input ready; combinational
fout_valid_o  output  1  registered output flit valid
fout_data_o  output  FLIT_WIDTH  registered output flit
fout_ready_i  input  1  downstream ready
pkt_cnt_o  output  PKT_CNT_WIDTH  forwarded-packet count (optional feature)

Behaviour:
- Clock and reset (decided): single clock clk; reset arst is asynchronous and active-high.
- Flit type encoding: 2'b00 HEAD, 2'b01 BODY, 2'b10 TAIL, 2'b11 HEAD_TAIL (single-flit packet).
- Reset values: fout_valid_o=0, fout_data_o=0, state=IDLE, rr_ptr=0, grant=0, pkt_cnt_o=0. fin_ready_o is all-zero while arst is high.
- Output stage: pipe_ready = !fout_valid_o || fout_ready_i. A transfer from input g occurs when fin_valid_i[g] && fin_ready_o[g]. On a transfer, fout_data_o<=flit and fout_valid_o<=1. Otherwise, if fout_ready_i is high, fout_valid_o<=0. Data holds while fout_valid_o && !fout_ready_i.
- Latency: 1 cycle input to output. Throughput: 1 flit/cycle sustained.
- Eligibility in IDLE: input k is eligible iff req_i[k] && fin_valid_i[k] && type is HEAD or HEAD_TAIL.
- Non-head flits on an unlocked input are never acked. They stay stalled; this is not an error.
- IDLE state:
  - The winner is the first eligible index at or after rr_ptr, wrapping modulo NUM_INPUTS.
  - fin_ready_o[winner]=pipe_ready; all other readies are 0.
  - On a HEAD transfer: go to LOCKED with grant=winner.
  - On a HEAD_TAIL transfer: stay in IDLE, rr_ptr<=winner+1 (wraps).
  - If no input is eligible, or pipe_ready=0, there is no transfer and no state change.
- LOCKED state:
  - fin_ready_o[grant]=pipe_ready; all other readies are 0.
  - req_i is ignored while LOCKED.
  - On a TAIL transfer: go to IDLE, rr_ptr<=grant+1 (wraps).
  - A HEAD or HEAD_TAIL arriving while LOCKED is forwarded as a body flit (protocol violation, no recovery). The lock is kept until a TAIL flit.
  - Idle bubbles (fin_valid_i[grant]=0) do not release the lock.
- Back-to-back packets: a new head can be granted in the cycle after the tail transfer. There is one-cycle arbitration-free turnaround, and no bubble is inserted.
- Simultaneous output drain and new transfer in the same cycle: the register is reloaded and fout_valid_o stays 1.
- Reset mid-packet: the lock is discarded and the output is cleared. Upstream must also be reset; there is no partial-packet recovery.
- rr_ptr width is clog2(NUM_INPUTS). Wrap uses an explicit compare to NUM_INPUTS-1, so non-power-of-2 counts are supported.

Optional Feature:
Macro OUT_ARB_PKT_CNT_EN.
- Defined: pkt_cnt_o increments by 1 on every TAIL or HEAD_TAIL transfer. It wraps at 2^PKT_CNT_WIDTH and resets to 0.
- Undefined: pkt_cnt_o is tied to 0 and no counter logic is synthesised. Port list is unchanged.

Test Plan:
- Single HEAD_TAIL on input 2, fout_ready_i=1 -> fin_ready_o=4'b0100 that cycle; fout_valid_o=1 next cycle with the same data; rr_ptr=3; pkt_cnt_o=1 (macro on).
- 3-flit packet (HEAD, BODY, TAIL) on input 0 while input 1 holds a valid HEAD throughout -> input 1 ready stays 0 until input 0's TAIL transfers; input 1's HEAD goes out on the cycle after the tail.
- All 4 inputs present HEAD_TAIL continuously from reset -> grant order is 0,1,2,3,0; one flit per cycle; no bubbles.
- Mid-packet backpressure: fout_ready_i=0 for 3 cycles after the BODY flit -> fout_data_o holds BODY, fin_ready_o[grant]=0 during the stall, and the TAIL follows 1 cycle after ready returns.
- BODY flit on input 3 with req_i[3]=1 while IDLE, no other requests -> fin_ready_o=0, fout_valid_o stays 0 indefinitely.
- arst asserted after a HEAD transfer, before the TAIL -> fout_valid_o=0 immediately; after release a new HEAD on input 1 is granted (rr_ptr=0 scan).
